// File: rtl/arbitro_memoria_relacoes_pkg.sv
// rtl/arbitro_memoria_relacoes_pkg.sv - shared states, default widths and row-width formula for the relations-memory arbiter
package arbitro_memoria_relacoes_pkg;

    typedef enum logic {
        ST_LIVRE   = 1'b0,
        ST_TRAVADO = 1'b1
    } estado_t;

    localparam int NUM_REQ_DEF      = 2;
    localparam int ADDR_WIDTH_DEF   = 10;
    localparam int CUSTO_WIDTH_DEF  = 4;
    localparam int MAX_VIZINHOS_DEF = 8;
    localparam int CONFLITOS_WIDTH  = 16;

    // Same row layout as the neighbour locator: MAX_VIZINHOS packed {address, cost} relations.
    function automatic int relacoes_data_width(input int max_viz, input int addr_w, input int custo_w);
        return max_viz * (addr_w + custo_w);
    endfunction

endpackage

// File: rtl/arbitro_memoria_relacoes_rr_prioridade.sv
// rtl/arbitro_memoria_relacoes_rr_prioridade.sv - rotate-priority encoder: first request after ptr wins
module rr_prioridade #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    int         w_pos;
    logic [IDX_W-1:0] w_j;
    logic       w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_j     = '0;
        // Scan ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            w_j   = IDX_W'(w_pos);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_idx      = w_j;
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_memoria_relacoes.sv
// rtl/arbitro_memoria_relacoes.sv - round-robin arbiter with lock for the relations memory read port; option ARBITRO_CONTADOR_CONFLITOS_EN
module arbitro_memoria_relacoes
    import arbitro_memoria_relacoes_pkg::*;
#(
    parameter int NUM_REQ             = NUM_REQ_DEF,
    parameter int ADDR_WIDTH          = ADDR_WIDTH_DEF,
    parameter int CUSTO_WIDTH         = CUSTO_WIDTH_DEF,
    parameter int MAX_VIZINHOS        = MAX_VIZINHOS_DEF,
    parameter int RELACOES_DATA_WIDTH = relacoes_data_width(MAX_VIZINHOS, ADDR_WIDTH, CUSTO_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_in,
    input  logic [NUM_REQ-1:0]              lock_in,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]   addr_in,
    output logic [NUM_REQ-1:0]              gnt_out,
    output logic [NUM_REQ-1:0]              valid_out,
    output logic [RELACOES_DATA_WIDTH-1:0]  data_out,
    output logic                            mem_rd_enable_out,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr_out,
    input  logic [RELACOES_DATA_WIDTH-1:0]  mem_rd_data_in,
`ifdef ARBITRO_CONTADOR_CONFLITOS_EN
    output logic [CONFLITOS_WIDTH-1:0]      conflitos_out,
    input  logic                            conflitos_clr_in,
`endif
    output logic                            ocupado_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    estado_t            r_estado;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_valid;

    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [IDX_W-1:0]   w_rr_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_any;

    rr_prioridade #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req (req_in),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx)
    );

    // While locked only the owner can be served; an idle owner still holds the port.
    always_comb begin
        w_gnt = '0;
        w_idx = r_owner;
        if (r_estado == ST_TRAVADO) begin
            w_gnt[r_owner] = req_in[r_owner];
        end else begin
            w_gnt = w_rr_gnt;
            w_idx = w_rr_idx;
        end
    end

    assign w_any             = |w_gnt;
    assign w_sel_idx         = w_any ? w_idx : '0;
    assign gnt_out           = w_gnt;
    assign mem_rd_enable_out = w_any;
    assign mem_rd_addr_out   = addr_in[ADDR_WIDTH*w_sel_idx +: ADDR_WIDTH];
    assign data_out          = mem_rd_data_in;
    assign valid_out         = r_valid;
    assign ocupado_out       = (r_estado == ST_TRAVADO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= ST_LIVRE;
            r_ptr    <= IDX_W'(NUM_REQ - 1);
            r_owner  <= '0;
            r_valid  <= '0;
        end else begin
            r_valid <= w_gnt;
            if (w_any) begin
                r_ptr <= w_idx;
            end
            case (r_estado)
                ST_LIVRE: begin
                    if (w_any && lock_in[w_idx]) begin
                        r_owner  <= w_idx;
                        r_estado <= ST_TRAVADO;
                    end
                end
                ST_TRAVADO: begin
                    if (!lock_in[r_owner]) begin
                        r_estado <= ST_LIVRE;
                    end
                end
                default: r_estado <= ST_LIVRE;
            endcase
        end
    end

`ifdef ARBITRO_CONTADOR_CONFLITOS_EN
    logic [CONFLITOS_WIDTH-1:0] r_conflitos;
    logic                       w_conflito;

    assign w_conflito    = |(req_in & ~w_gnt);
    assign conflitos_out = r_conflitos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflitos <= '0;
        end else if (conflitos_clr_in) begin
            r_conflitos <= '0;
        end else if (w_conflito && (r_conflitos != {CONFLITOS_WIDTH{1'b1}})) begin
            r_conflitos <= r_conflitos + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_memoria_relacoes.sv
// tb/tb_arbitro_memoria_relacoes.sv - self-checking bench with a reference arbiter model; option ARBITRO_CONTADOR_CONFLITOS_EN
module tb_arbitro_memoria_relacoes;

    localparam int NR = 2;
    localparam int AW = 10;
    localparam int CW = 4;
    localparam int MV = 8;
    localparam int DW = MV * (AW + CW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req_in = '0;
    logic [NR-1:0] lock_in = '0;
    logic [AW*NR-1:0] addr_in = '0;
    logic [NR-1:0] gnt_out;
    logic [NR-1:0] valid_out;
    logic [DW-1:0] data_out;
    logic          mem_rd_enable_out;
    logic [AW-1:0] mem_rd_addr_out;
    logic [DW-1:0] mem_rd_data_in = '0;
    logic          ocupado_out;
    logic          conflitos_clr_in = 1'b0;
    logic [15:0]   conflitos_out;

    arbitro_memoria_relacoes #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .CUSTO_WIDTH(CW), .MAX_VIZINHOS(MV)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_in            (req_in),
        .lock_in           (lock_in),
        .addr_in           (addr_in),
        .gnt_out           (gnt_out),
        .valid_out         (valid_out),
        .data_out          (data_out),
        .mem_rd_enable_out (mem_rd_enable_out),
        .mem_rd_addr_out   (mem_rd_addr_out),
        .mem_rd_data_in    (mem_rd_data_in),
`ifdef ARBITRO_CONTADOR_CONFLITOS_EN
        .conflitos_out     (conflitos_out),
        .conflitos_clr_in  (conflitos_clr_in),
`endif
        .ocupado_out       (ocupado_out)
    );

`ifndef ARBITRO_CONTADOR_CONFLITOS_EN
    assign conflitos_out = '0;
`endif

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
        logic [3:0] c;
        c = a[3:0] ^ 4'hA;
        return {MV{a, c}};
    endfunction

    always @(posedge clk) begin
        if (mem_rd_enable_out) mem_rd_data_in <= memfn(mem_rd_addr_out);
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner = -1 means the port is free.
    int            m_ptr;
    int            m_owner;
    int            m_conf;
    int            e_idx;
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_valid;
    logic [AW-1:0] e_addr;
    logic [AW-1:0] e_prev_addr;
    bit            pend_clr = 1'b0;

    function automatic void model_reset();
        m_ptr = NR - 1; m_owner = -1; m_conf = 0;
        e_idx = -1; e_gnt = '0; e_valid = '0; e_addr = '0; e_prev_addr = '0;
    endfunction

    function automatic void model_eval();
        int j;
        e_idx = -1;
        e_gnt = '0;
        if (m_owner >= 0) begin
            if (req_in[m_owner]) e_idx = m_owner;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                j = (m_ptr + k) % NR;
                if (e_idx < 0 && req_in[j]) e_idx = j;
            end
        end
        if (e_idx >= 0) e_gnt[e_idx] = 1'b1;
        e_addr = addr_in[AW*((e_idx < 0) ? 0 : e_idx) +: AW];
    endfunction

    function automatic void model_commit();
        int prev_owner;
        prev_owner = m_owner;
        if (prev_owner >= 0 && !lock_in[prev_owner]) m_owner = -1;
        if (prev_owner < 0 && e_idx >= 0 && lock_in[e_idx]) m_owner = e_idx;
        if (e_idx >= 0) m_ptr = e_idx;
        if (conflitos_clr_in) m_conf = 0;
        else if ((req_in & ~e_gnt) != '0 && m_conf < 65535) m_conf = m_conf + 1;
        e_valid = e_gnt;
        e_prev_addr = e_addr;
    endfunction

    task automatic tick(input logic [NR-1:0] r, input logic [NR-1:0] l,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(posedge clk);
        model_commit();
        #1;
        req_in = r; lock_in = l; addr_in = {a1, a0};
        conflitos_clr_in = pend_clr; pend_clr = 1'b0;
        model_eval();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_in = '0; lock_in = '0; conflitos_clr_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (valid_out !== 2'b00 || ocupado_out !== 1'b0 || gnt_out !== 2'b00 || mem_rd_enable_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state valid=%b ocupado=%b gnt=%b en=%b required 00 0 00 0",
                     valid_out, ocupado_out, gnt_out, mem_rd_enable_out);
        end
        n_checks++;
        if (conflitos_out !== 16'd0) begin
            n_errors++; $display("FAIL reset_conflitos got %h required 0", conflitos_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        tick(2'b10, 2'b00, 10'h3FF, 10'h005);
        n_checks++;
        if (gnt_out !== 2'b10 || mem_rd_addr_out !== 10'h005 || mem_rd_enable_out !== 1'b1) begin
            n_errors++;
            $display("FAIL single_grant gnt=%b addr=%h en=%b required 10 005 1", gnt_out, mem_rd_addr_out, mem_rd_enable_out);
        end
        tick(2'b00, 2'b00, 10'h000, 10'h000);
        n_checks++;
        if (valid_out !== 2'b10 || data_out !== memfn(10'h005)) begin
            n_errors++;
            $display("FAIL single_valid valid=%b data=%h required 10 %h", valid_out, data_out, memfn(10'h005));
        end
        n_checks++;
        if (mem_rd_enable_out !== 1'b0 || mem_rd_addr_out !== 10'h000) begin
            n_errors++;
            $display("FAIL idle_port en=%b addr=%h required 0 000", mem_rd_enable_out, mem_rd_addr_out);
        end
    endtask

    task automatic test_alternate();
        logic [NR-1:0] prev;
        do_reset();
        prev = 2'b00;
        for (int c = 0; c < 6; c++) begin
            tick(2'b11, 2'b00, AW'(c), AW'(c + 100));
            n_checks++;
            if (gnt_out !== ((c % 2 == 0) ? 2'b01 : 2'b10) || valid_out !== prev) begin
                n_errors++;
                $display("FAIL alternate c=%0d gnt=%b valid=%b required %b %b", c, gnt_out, valid_out,
                         (c % 2 == 0) ? 2'b01 : 2'b10, prev);
            end
            prev = gnt_out;
        end
    endtask

    task automatic test_lock();
        logic [NR-1:0] lk [4];
        logic [NR-1:0] eg [4];
        logic          eo [4];
        lk = '{2'b01, 2'b01, 2'b00, 2'b00};
        eg = '{2'b01, 2'b01, 2'b01, 2'b10};
        eo = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick(2'b11, lk[c], 10'h010, 10'h020);
            n_checks++;
            if (gnt_out !== eg[c] || ocupado_out !== eo[c]) begin
                n_errors++;
                $display("FAIL lock c=%0d gnt=%b ocupado=%b required %b %b", c, gnt_out, ocupado_out, eg[c], eo[c]);
            end
        end
    endtask

    task automatic test_lock_idle_owner();
        do_reset();
        tick(2'b01, 2'b01, 10'h001, 10'h002);
        for (int c = 0; c < 4; c++) begin
            tick(2'b10, (c < 3) ? 2'b01 : 2'b00, 10'h001, 10'h002);
            n_checks++;
            if (gnt_out !== 2'b00 || mem_rd_enable_out !== 1'b0 || ocupado_out !== 1'b1) begin
                n_errors++;
                $display("FAIL idle_owner c=%0d gnt=%b en=%b ocupado=%b required 00 0 1", c, gnt_out, mem_rd_enable_out, ocupado_out);
            end
        end
        tick(2'b10, 2'b00, 10'h001, 10'h002);
        n_checks++;
        if (gnt_out !== 2'b10 || mem_rd_addr_out !== 10'h002) begin
            n_errors++;
            $display("FAIL idle_owner_release gnt=%b addr=%h required 10 002", gnt_out, mem_rd_addr_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(2'b01, 2'b01, 10'h0AA, 10'h0BB);
        @(posedge clk);
        #1;
        rst_n = 1'b0; req_in = '0; lock_in = '0;
        model_reset();
        #1;
        n_checks++;
        if (valid_out !== 2'b00 || ocupado_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid valid=%b ocupado=%b required 00 0", valid_out, ocupado_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2'b11, 2'b00, 10'h0AA, 10'h0BB);
        n_checks++;
        if (gnt_out !== 2'b01) begin
            n_errors++; $display("FAIL reset_mid_first gnt=%b required 01", gnt_out);
        end
    endtask

    task automatic test_random();
        logic [NR-1:0] r, l;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            r = NR'($urandom);
            l = NR'($urandom) & NR'($urandom);
            tick(r, l, AW'($urandom), AW'($urandom));
            n_checks++;
            if (gnt_out !== e_gnt || mem_rd_enable_out !== (e_gnt != '0) || mem_rd_addr_out !== e_addr ||
                valid_out !== e_valid || ocupado_out !== (m_owner >= 0)) begin
                n_errors++;
                $display("FAIL random c=%0d gnt=%b addr=%h valid=%b ocupado=%b required %b %h %b %b",
                         c, gnt_out, mem_rd_addr_out, valid_out, ocupado_out, e_gnt, e_addr, e_valid, m_owner >= 0);
            end
            if (e_valid != '0) begin
                n_checks++;
                if (data_out !== memfn(e_prev_addr)) begin
                    n_errors++;
                    $display("FAIL random_data c=%0d got %h required %h", c, data_out, memfn(e_prev_addr));
                end
            end
        end
    endtask

`ifdef ARBITRO_CONTADOR_CONFLITOS_EN
    task automatic test_contador();
        do_reset();
        for (int c = 0; c < 20; c++) tick(2'b11, 2'b00, 10'h001, 10'h002);
        tick(2'b00, 2'b00, 10'h001, 10'h002);
        n_checks++;
        if (conflitos_out !== 16'd20 || conflitos_out !== 16'(m_conf)) begin
            n_errors++; $display("FAIL conflitos_20 got %0d required 20", conflitos_out);
        end
        pend_clr = 1'b1;
        tick(2'b11, 2'b00, 10'h001, 10'h002);
        tick(2'b00, 2'b00, 10'h001, 10'h002);
        n_checks++;
        if (conflitos_out !== 16'd0) begin
            n_errors++; $display("FAIL conflitos_clr got %0d required 0", conflitos_out);
        end
        for (int c = 0; c < 65534; c++) tick(2'b11, 2'b00, 10'h001, 10'h002);
        tick(2'b00, 2'b00, 10'h001, 10'h002);
        n_checks++;
        if (conflitos_out !== 16'hFFFE) begin
            n_errors++; $display("FAIL conflitos_preload got %h required FFFE", conflitos_out);
        end
        for (int c = 0; c < 5; c++) tick(2'b11, 2'b00, 10'h001, 10'h002);
        tick(2'b00, 2'b00, 10'h001, 10'h002);
        n_checks++;
        if (conflitos_out !== 16'hFFFF) begin
            n_errors++; $display("FAIL conflitos_sat got %h required FFFF", conflitos_out);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_lock();
        test_lock_idle_owner();
        test_reset_mid();
        test_random();
`ifdef ARBITRO_CONTADOR_CONFLITOS_EN
        test_contador();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
